traffic_light_sequencer: RTL and testbench

Parametrised traffic-light sequencer, the successor to the fixed two-mode controller. Drives red, amber and green lamps through a RED -> GREEN -> AMBER cycle, with per-mode phase durations and an end-of-phase blink warning. Adds three things the earlier controller lacks: a flashing-amber maintenance mode, a tick-enable prescaler input, and status outputs. It sits between the system tick generator and the lamp drivers.

---
 rtl/traffic_light_sequencer_if.sv | 20 ++
 rtl/traffic_light_sequencer.sv | 126 ++++++++++++
 tb/tb_traffic_light_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/traffic_light_sequencer_if.sv
// Lamp-driver side of the traffic-light sequencer: tic/mode inputs and registered lamp/status outputs.
interface traffic_light_sequencer_if;
  logic       tick;
  logic [1:0] mode;
  logic       red;
  logic       amber;
  logic       green;
  logic [1:0] phase;
  logic       cycle_start;

  modport master (
    output tick, mode,
    input  red, amber, green, phase, cycle_start
  );

  modport slave (
    input  tick, mode,
    output red, amber, green, phase, cycle_start
  );
endinterface

// File: rtl/traffic_light_sequencer.sv
// RED -> GREEN -> AMBER sequencer with per-mode durations, end-of-phase blink,
// flashing-amber maintenance mode and a one-clock cycle_start pulse on entry to RED.
module traffic_light_sequencer #(
  parameter int CNT_W      = 10,
  parameter int RED_M0     = 350,
  parameter int GREEN_M0   = 350,
  parameter int RED_M1     = 200,
  parameter int GREEN_M1   = 200,
  parameter int AMBER_TICS = 30,
  parameter int BLINK_TICS = 3,
  parameter int FLASH_TICS = 50
) (
  input  logic                        clock,
  input  logic                        reset,
  traffic_light_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    S_RED   = 2'd0,
    S_GREEN = 2'd1,
    S_AMBER = 2'd2,
    S_FLASH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RED0_R   = CNT_W'(RED_M0 - 1);
  localparam logic [CNT_W-1:0] RED1_R   = CNT_W'(RED_M1 - 1);
  localparam logic [CNT_W-1:0] GREEN0_R = CNT_W'(GREEN_M0 - 1);
  localparam logic [CNT_W-1:0] GREEN1_R = CNT_W'(GREEN_M1 - 1);
  localparam logic [CNT_W-1:0] AMBER_R  = CNT_W'(AMBER_TICS - 1);
  localparam logic [CNT_W-1:0] FLASH_R  = CNT_W'(FLASH_TICS - 1);
  localparam logic [CNT_W-1:0] BLINK_R  = CNT_W'(BLINK_TICS);
  localparam logic             RED_RST  = (RED_M0 - 1 >= BLINK_TICS) || ((RED_M0 - 1) % 2 == 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] r, r_nxt;
  logic             m, m_nxt;
  logic             famb, famb_nxt;
  logic             red_q, amber_q, green_q, cs_q;
  logic             red_nxt, amber_nxt, green_nxt, cs_nxt;
  logic             lit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_RED;
      r       <= RED0_R;
      m       <= 1'b0;
      famb    <= 1'b0;
      red_q   <= RED_RST;
      amber_q <= 1'b0;
      green_q <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      r       <= r_nxt;
      m       <= m_nxt;
      famb    <= famb_nxt;
      red_q   <= red_nxt;
      amber_q <= amber_nxt;
      green_q <= green_nxt;
      cs_q    <= cs_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    m_nxt     = m;
    famb_nxt  = famb;
    cs_nxt    = 1'b0;
    if (bus.tick) begin
      if (bus.mode[1]) begin
        // Maintenance request outranks any phase transition due on this tick.
        if (state != S_FLASH) begin
          state_nxt = S_FLASH;
          r_nxt     = FLASH_R;
          famb_nxt  = 1'b1;
        end else if (r == '0) begin
          r_nxt     = FLASH_R;
          famb_nxt  = ~famb;
        end else begin
          r_nxt     = r - CNT_W'(1);
        end
      end else if (state == S_FLASH) begin
        state_nxt = S_RED;
        m_nxt     = bus.mode[0];
        r_nxt     = bus.mode[0] ? RED1_R : RED0_R;
        cs_nxt    = 1'b1;
      end else if (r != '0) begin
        r_nxt = r - CNT_W'(1);
      end else begin
        unique case (state)
          S_RED: begin
            state_nxt = S_GREEN;
            r_nxt     = m ? GREEN1_R : GREEN0_R;
          end
          S_GREEN: begin
            state_nxt = S_AMBER;
            r_nxt     = AMBER_R;
          end
          S_AMBER: begin
            state_nxt = S_RED;
            m_nxt     = bus.mode[0];
            r_nxt     = bus.mode[0] ? RED1_R : RED0_R;
            cs_nxt    = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Lamps are decoded from the next-state values so they register alongside state and r.
  always_comb begin
    lit       = (r_nxt >= BLINK_R) || r_nxt[0];
    red_nxt   = (state_nxt == S_RED) && lit;
    green_nxt = (state_nxt == S_GREEN) && lit;
    amber_nxt = ((state_nxt == S_AMBER) && lit) || ((state_nxt == S_FLASH) && famb_nxt);
  end

  assign bus.red         = red_q;
  assign bus.amber       = amber_q;
  assign bus.green       = green_q;
  assign bus.phase       = state;
  assign bus.cycle_start = cs_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench for traffic_light_sequencer using the small test-plan parameter set.
module tb_traffic_light_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  traffic_light_sequencer_if bus ();

  traffic_light_sequencer #(
    .CNT_W(4), .RED_M0(6), .GREEN_M0(6), .RED_M1(5), .GREEN_M1(5),
    .AMBER_TICS(4), .BLINK_TICS(3), .FLASH_TICS(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0]  v;    // {red, amber, green, phase[1:0], cycle_start}
    int unsigned id;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned step_id  = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  // Hand-computed lamp values per remaining-tic position, first tic of a phase first.
  bit pat6 [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  bit pat5 [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  bit pat4 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit flpat[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  function automatic logic [5:0] mk(input int ph, input bit lamp, input bit cs);
    logic [1:0] p;
    p = 2'(ph);
    return {(ph == 0) && lamp, ((ph == 2) || (ph == 3)) && lamp, (ph == 1) && lamp, p, cs};
  endfunction

  function automatic bit tab(input int len, input int i);
    if (len == 6) return pat6[i];
    if (len == 5) return pat5[i];
    return pat4[i];
  endfunction

  task automatic push(input int ph, input bit lamp, input bit cs);
    exp_t e;
    step_id = step_id + 1;
    e.v  = mk(ph, lamp, cs);
    e.id = step_id;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit t, input logic [1:0] md, input int ph, input bit lamp, input bit cs);
    bus.tick = t;
    bus.mode = md;
    @(posedge clock);
    #1;
    push(ph, lamp, cs);
  endtask

  task automatic run(input int ph, input int len, input int first, input int cnt,
                     input logic [1:0] md, input bit cs_first);
    for (int i = first; i < first + cnt; i++)
      step(1'b1, md, ph, tab(len, i), (i == first) && cs_first);
  endtask

  // Monitor: compares whenever the stimulus side has queued an expectation.
  always @(negedge clock or posedge reset) begin
    exp_t       e;
    logic [5:0] act;
    #1;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {bus.red, bus.amber, bus.green, bus.phase, bus.cycle_start};
      n_checks = n_checks + 1;
      if (act === e.v)
        n_pass = n_pass + 1;
      else
        $display("FAIL step%0d r/a/g/phase/cs got=%b required=%b", e.id, act, e.v);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 1'b0;
    bus.mode = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    push(0, 1'b1, 1'b0);                 // reset state: RED, r=5

    // Full cycle with mode 0; cycle_start on re-entry to RED.
    bus.tick = 1'b1;
    run(0, 6, 1, 5, 2'b00, 1'b0);
    run(1, 6, 0, 6, 2'b00, 1'b0);
    run(2, 4, 0, 4, 2'b00, 1'b0);
    run(0, 6, 0, 6, 2'b00, 1'b1);

    // Mode 1 requested mid-GREEN takes effect from the next RED.
    run(1, 6, 0, 3, 2'b00, 1'b0);
    run(1, 6, 3, 3, 2'b01, 1'b0);
    run(2, 4, 0, 4, 2'b01, 1'b0);
    run(0, 5, 0, 5, 2'b01, 1'b1);
    run(1, 5, 0, 5, 2'b01, 1'b0);
    run(2, 4, 0, 4, 2'b01, 1'b0);

    // Tick gating back in mode 0; mode changes while tick=0 are ignored.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 2'b00, 0, pat6[i], i == 0);
      if (i % 2 == 0) begin
        step(1'b0, 2'b10, 0, pat6[i], 1'b0);
        step(1'b0, 2'b11, 0, pat6[i], 1'b0);
      end
    end

    // Flash request at the last RED tic wins over RED -> GREEN.
    for (int i = 0; i < 6; i++)
      step(1'b1, 2'b10, 3, flpat[i], 1'b0);

    // Flash exit into RED with mode 1 latched: r=4 on entry.
    step(1'b1, 2'b01, 0, 1'b1, 1'b1);
    run(0, 5, 1, 4, 2'b01, 1'b0);
    run(1, 5, 0, 5, 2'b01, 1'b0);
    run(2, 4, 0, 2, 2'b01, 1'b0);

    // Asynchronous reset during AMBER, observed before the next rising edge.
    @(negedge clock);
    #2;
    push(0, 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    run(0, 6, 1, 5, 2'b00, 1'b0);
    run(1, 6, 0, 1, 2'b00, 1'b0);

    bus.tick = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++)
      @(negedge clock);
    if (exp_q.size() != 0) begin
      n_checks = n_checks + 1;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
